// File: rtl/modulo_controle_disparo.sv
// Shot controller for the 5x7 LED-matrix naval game: button debounce, shot classification, score state.
// Optional shot limit enabled by defining LIMITE_TIROS_EN.
module modulo_controle_disparo #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MAX_TIROS       = 20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        button_clk,
  input  logic [5:0]  hh2,
  input  logic [34:0] m_po,
  output logic [34:0] m_shot,
  output logic [34:0] m_hit,
  output logic [3:0]  status,
  output logic [5:0]  tiros,
  output logic [5:0]  acertos,
  output logic        fim_jogo
);

  localparam int unsigned     CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   LP_DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef LIMITE_TIROS_EN
  localparam bit              LP_LIMIT_EN = 1'b1;
`else
  localparam bit              LP_LIMIT_EN = 1'b0;
`endif

  localparam logic [3:0] ST_READY   = 4'd0;
  localparam logic [3:0] ST_HIT     = 4'd1;
  localparam logic [3:0] ST_MISS    = 4'd2;
  localparam logic [3:0] ST_REPEAT  = 4'd3;
  localparam logic [3:0] ST_INVALID = 4'd4;
  localparam logic [3:0] ST_VICTORY = 4'd5;
  localparam logic [3:0] ST_OVER    = 4'd6;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_UPDATE, S_END} state_t;
  typedef enum logic [1:0] {C_INVALID, C_REPEAT, C_HIT, C_MISS} class_t;

  state_t          r_state, w_next_state;
  class_t          r_class, w_class;
  logic            r_sync1, r_sync2, r_db_level, r_db_prev;
  logic [CW-1:0]   r_db_cnt;
  logic [5:0]      r_coord;
  logic [34:0]     r_mask, w_mask;
  logic [34:0]     r_m_shot, r_m_hit, w_hit_new;
  logic [5:0]      r_tiros, r_acertos, w_tiros_new, w_acertos_new, w_idx;
  logic [3:0]      r_status, w_status_upd;
  logic [2:0]      w_row, w_col;
  logic            w_press, w_valid, w_is_shot, w_victory, w_limit, w_go_end;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_db_level <= 1'b1;
      r_db_prev  <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_sync1   <= button_clk;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_level;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == LP_DB_LAST) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CW'(1);
      end
    end
  end

  // Button is active-low: only the debounced falling edge fires a shot.
  assign w_press = r_db_prev & ~r_db_level;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_row   = r_coord[5:3];
    w_col   = r_coord[2:0];
    w_valid = (w_row <= 3'd6) && (w_col <= 3'd4);
    w_idx   = 6'(w_row) * 6'd5 + 6'(w_col);
    w_mask  = w_valid ? (35'd1 << (6'd34 - w_idx)) : '0;
    w_class = C_MISS;
    if (!w_valid)                  w_class = C_INVALID;
    else if (|(r_m_shot & w_mask)) w_class = C_REPEAT;
    else if (|(m_po & w_mask))     w_class = C_HIT;
  end

  always_comb begin
    w_is_shot     = (r_class == C_HIT) || (r_class == C_MISS);
    w_hit_new     = (r_class == C_HIT) ? (r_m_hit | r_mask) : r_m_hit;
    w_tiros_new   = (r_tiros == 6'd63) ? r_tiros : r_tiros + 6'd1;
    w_acertos_new = (r_acertos == 6'd63) ? r_acertos : r_acertos + 6'd1;
    w_victory     = w_is_shot && (m_po != '0) && ((m_po & ~w_hit_new) == '0);
    w_limit       = LP_LIMIT_EN && w_is_shot && !w_victory && (w_tiros_new == 6'(MAX_TIROS));
    w_go_end      = w_victory || w_limit;
    unique case (r_class)
      C_INVALID: w_status_upd = ST_INVALID;
      C_REPEAT:  w_status_upd = ST_REPEAT;
      C_HIT:     w_status_upd = ST_HIT;
      default:   w_status_upd = ST_MISS;
    endcase
    if (w_victory)    w_status_upd = ST_VICTORY;
    else if (w_limit) w_status_upd = ST_OVER;
  end

  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (w_press) w_next_state = S_CHECK;
      S_CHECK:  w_next_state = S_UPDATE;
      S_UPDATE: w_next_state = w_go_end ? S_END : S_IDLE;
      default:  w_next_state = S_END;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_coord   <= '0;
      r_class   <= C_INVALID;
      r_mask    <= '0;
      r_m_shot  <= '0;
      r_m_hit   <= '0;
      r_tiros   <= '0;
      r_acertos <= '0;
      r_status  <= ST_READY;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_press) r_coord <= hh2;
        S_CHECK: begin
          r_class <= w_class;
          r_mask  <= w_mask;
        end
        S_UPDATE: begin
          r_status <= w_status_upd;
          if (w_is_shot) begin
            r_m_shot <= r_m_shot | r_mask;
            r_m_hit  <= w_hit_new;
            r_tiros  <= w_tiros_new;
            if (r_class == C_HIT) r_acertos <= w_acertos_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_shot   = r_m_shot;
  assign m_hit    = r_m_hit;
  assign status   = r_status;
  assign tiros    = r_tiros;
  assign acertos  = r_acertos;
  assign fim_jogo = (r_state == S_END);

endmodule

// File: tb/tb_modulo_controle_disparo.sv
// Self-checking bench for modulo_controle_disparo: directed plan plus randomized games vs a board-level model.
module tb_modulo_controle_disparo;

  localparam int D    = 4;
  localparam int MAXT = 3;

  logic        clk = 1'b0;
  logic        clr, button_clk;
  logic [5:0]  hh2;
  logic [34:0] m_po;
  logic [34:0] m_shot, m_hit;
  logic [3:0]  status;
  logic [5:0]  tiros, acertos;
  logic        fim_jogo;

  always #5 clk = ~clk;

  modulo_controle_disparo #(.DEBOUNCE_CYCLES(D), .MAX_TIROS(MAXT)) dut (
    .clk(clk), .clr(clr), .button_clk(button_clk), .hh2(hh2), .m_po(m_po),
    .m_shot(m_shot), .m_hit(m_hit), .status(status), .tiros(tiros),
    .acertos(acertos), .fim_jogo(fim_jogo)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Board-level reference state
  logic [34:0] e_shot, e_hit;
  int          e_tiros, e_acertos, e_status;
  bit          e_end;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".m_shot"},   64'(m_shot),   64'(e_shot));
    check({tag, ".m_hit"},    64'(m_hit),    64'(e_hit));
    check({tag, ".tiros"},    64'(tiros),    64'(e_tiros));
    check({tag, ".acertos"},  64'(acertos),  64'(e_acertos));
    check({tag, ".status"},   64'(status),   64'(e_status));
    check({tag, ".fim_jogo"}, 64'(fim_jogo), 64'(e_end));
  endtask

  function automatic int cell_bit(input int r, input int c);
    return 34 - (5 * r + c);
  endfunction

  task automatic model_reset();
    e_shot = '0; e_hit = '0; e_tiros = 0; e_acertos = 0; e_status = 0; e_end = 0;
  endtask

  task automatic model_shot(input logic [5:0] coord);
    int r, c, p;
    if (e_end) return;
    r = int'(coord[5:3]);
    c = int'(coord[2:0]);
    if (r > 6 || c > 4) begin
      e_status = 4;
      return;
    end
    p = cell_bit(r, c);
    if (e_shot[p]) begin
      e_status = 3;
      return;
    end
    e_shot[p] = 1'b1;
    if (e_tiros < 63) e_tiros++;
    if (m_po[p]) begin
      e_hit[p] = 1'b1;
      if (e_acertos < 63) e_acertos++;
      e_status = 1;
    end else begin
      e_status = 2;
    end
    if (m_po != '0 && (m_po & ~e_hit) == '0) begin
      e_status = 5;
      e_end = 1;
    end
`ifdef LIMITE_TIROS_EN
    else if (e_tiros == MAXT) begin
      e_status = 6;
      e_end = 1;
    end
`endif
  endtask

  task automatic clear_dut();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    model_reset();
  endtask

  // Clean press: outputs must still be old after 2+D+2 edges and new after 2+D+3 edges.
  task automatic do_shot(input logic [5:0] coord, input string tag);
    @(negedge clk);
    hh2 = coord;
    button_clk = 1'b0;
    repeat (D + 3) @(posedge clk);
    #1 hh2 = 6'($urandom);
    @(posedge clk);
    #1 check_all({tag, ".pre"});
    @(posedge clk);
    #1 model_shot(coord);
    check_all({tag, ".post"});
    @(negedge clk) button_clk = 1'b1;
    repeat (D + 6) @(posedge clk);
    #1 check_all({tag, ".rel"});
  endtask

  task automatic bounce_shot(input logic [5:0] coord);
    @(negedge clk) hh2 = coord;
    for (int i = 0; i < 10; i++) begin
      button_clk = i[0];
      repeat (2) @(negedge clk);
    end
    check_all("bounce.mid");
    button_clk = 1'b0;
    repeat (D + 12) @(negedge clk);
    model_shot(coord);
    check_all("bounce.held");
    button_clk = 1'b1;
    repeat (D + 6) @(negedge clk);
    check_all("bounce.rel");
  endtask

  task automatic clr_mid_check(input logic [5:0] coord);
    @(negedge clk);
    hh2 = coord;
    button_clk = 1'b0;
    repeat (D + 3) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_reset();
    check_all("clrmid.reset");
    repeat (D + 4) @(posedge clk);
    #1 check_all("clrmid.pre");
    @(posedge clk);
    #1 model_shot(coord);
    check_all("clrmid.post");
    @(negedge clk) button_clk = 1'b1;
    repeat (D + 6) @(posedge clk);
  endtask

  initial begin
    logic [5:0]  ships[$];
    logic [34:0] po;
    logic [5:0]  coord;
    int          nships, r, c, p;

    clr = 1'b1; button_clk = 1'b1; hh2 = '0; m_po = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    model_reset();
    check_all("reset");

    // Directed plan: ships at (0,0) and (6,4)
    m_po = '0;
    m_po[34] = 1'b1;
    m_po[0]  = 1'b1;
    do_shot(6'b000_000, "hit00");
    check("hit00.status_const", 64'(status), 64'd1);
    check("hit00.mhit34", 64'(m_hit[34]), 64'd1);
    do_shot(6'b001_010, "miss12");
    check("miss12.shot27", 64'(m_shot[27]), 64'd1);
    check("miss12.tiros_const", 64'(tiros), 64'd2);
    do_shot(6'b001_010, "repeat12");
    check("repeat12.status_const", 64'(status), 64'd3);
    do_shot(6'b111_000, "inv_row");
    do_shot(6'b000_101, "inv_col");
    check("inv_col.status_const", 64'(status), 64'd4);
    bounce_shot(6'b110_100);
    check("victory.status_const", 64'(status), 64'd5);
    check("victory.fim_const", 64'(fim_jogo), 64'd1);
    do_shot(6'b011_011, "end_ignored");
    clear_dut();
    check_all("clr_after_end");

    // Reset while a shot is in CHECK; the held button then fires once more
    m_po = 35'd1 << 20;
    do_shot(6'b000_001, "pre_clrmid");
    clr_mid_check(6'b010_011);

`ifdef LIMITE_TIROS_EN
    clear_dut();
    m_po = 35'd1 << 5;
    do_shot(6'b000_000, "lim1");
    do_shot(6'b000_001, "lim2");
    do_shot(6'b000_010, "lim3");
    check("limit.status_const", 64'(status), 64'd6);
    do_shot(6'b000_011, "lim_ignored");
`endif

    // Randomized games; game 0 has an empty preset so victory must never appear
    for (int g = 0; g < 6; g++) begin
      clear_dut();
      ships.delete();
      po = '0;
      nships = (g == 0) ? 0 : int'($urandom_range(2, 3));
      while (ships.size() < nships) begin
        r = int'($urandom_range(0, 6));
        c = int'($urandom_range(0, 4));
        p = cell_bit(r, c);
        if (!po[p]) begin
          po[p] = 1'b1;
          ships.push_back({3'(r), 3'(c)});
        end
      end
      m_po = po;
      for (int s = 0; s < 10; s++) begin
        case ($urandom_range(0, 4))
          0:       coord = 6'($urandom);
          1, 2:    coord = (ships.size() > 0) ? ships[$urandom_range(0, ships.size() - 1)]
                                              : 6'($urandom);
          default: coord = {3'($urandom_range(0, 6)), 3'($urandom_range(0, 4))};
        endcase
        do_shot(coord, $sformatf("g%0d_s%0d", g, s));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/modulo_controle_disparo.md
# modulo_controle_disparo

Shot controller for the 5×7 LED-matrix naval game. It debounces the raw confirm button and latches the row/column coordinate from the switches. It classifies each shot against the ship preset matrix and keeps the registered shot/hit matrices, counters and status code. Those outputs feed the display stage: the column-scan multiplexers and the 7-segment digit multiplexer.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive equal synchronized samples required to accept a new button level.
- MAX_TIROS, 20: shot limit. Used only under `LIMITE_TIROS_EN`.
- clk  in  1  system clock.
- clr  in  1  reset, synchronous, active-high.
- One clock (`clk`); reset is synchronous and active-high (`clr`).
- button_clk  in  1  raw confirm button. Active-low, since pressed = 0. Asynchronous to clk.
- hh2  in  6  coordinate: [5:3] row 0..6 (top = 0), [2:0] column 0..4 (left = 0).
- m_po  in  35  ship preset matrix. Bit 34−(5·row+col) = ship cell.
- m_shot  out  35  cells already fired on. Same bit mapping.
- m_hit  out  35  cells fired on that held a ship.
- status  out  4  0 ready, 1 hit, 2 miss, 3 repeated, 4 invalid, 5 victory, 6 game over.
- tiros  out  6  accepted-shot count, saturating at 63.
- acertos  out  6  hit count, saturating at 63.
- fim_jogo  out  1  high while in END.

## Operation
- Button path:
  - 2-FF synchronizer, then a debounce counter of width clog2(DEBOUNCE_CYCLES+1).
  - The counter resets whenever the synchronized sample equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the sample.
  - A debounced 1→0 transition produces a one-cycle `press` pulse. Release produces nothing.
- FSM states: IDLE, CHECK, UPDATE, END.
  - IDLE: on `press`, latch hh2 into coord register → CHECK. Otherwise stay.
  - CHECK: compute index = 5·row+col and classify, in priority order:
    - invalid: row>6 or col>4.
    - repeated: m_shot bit already set.
    - hit: m_po bit set.
    - miss: otherwise.
    - m_po is sampled in this cycle. Next state UPDATE.
  - UPDATE, per classification:
    - invalid / repeated: set status to 4 / 3. No matrix or counter change.
    - hit: set m_shot and m_hit bits, increment tiros and acertos, status 1.
    - miss: set the m_shot bit, increment tiros, status 2.
    - Victory check uses the post-update m_hit: m_po ≠ 0 and (m_po & ~m_hit_new) = 0 → status 5, go to END. Otherwise → IDLE.
  - END: all presses ignored, outputs frozen, fim_jogo=1. Leave only via clr.
- Counters saturate at 63 and never wrap.
- Reset values:
  - m_shot = 0, m_hit = 0, tiros = 0, acertos = 0, status = 0, fim_jogo = 0, state IDLE.
  - Debounced level = released (1), debounce counter = 0, synchronizer = 1.

## Timing
- `press` is high in cycle P, with hh2 sampled in P. CHECK runs in P+1 and UPDATE in P+2. New outputs are visible from P+3.
- From a stable button press to new outputs: 2 sync + DEBOUNCE_CYCLES + 3 cycles.
- `press` during CHECK/UPDATE/END is dropped, never queued.
- hh2 changes after cycle P have no effect on the current shot.
- clr wins over every other event in the same cycle, including mid-CHECK/UPDATE. The pending shot is discarded.
- A button held across clr yields exactly one shot after DEBOUNCE_CYCLES, because the debounced level resets to released.
- m_po = 0: victory is never declared.

## Configuration
- `LIMITE_TIROS_EN` defined:
  - In UPDATE, after a hit or miss, no victory and tiros_new = MAX_TIROS → status 6 and go to END.
  - Victory takes priority over game over on the same shot.
- Not defined: no limit, status 6 is never produced, MAX_TIROS is unused.

## Test plan
- Bench uses DEBOUNCE_CYCLES=4. clr; m_po bit 34 set (row 0, col 0); hh2=6'b000_000; press → status=1, m_hit[34]=1, tiros=1, acertos=1, outputs at P+3.
- hh2=6'b001_010 (row 1, col 2), not a ship cell → status=2, m_shot[27]=1, m_hit unchanged, tiros=2. Repeat the same coordinate → status=3, tiros stays 2.
- hh2=6'b111_000 and hh2=6'b000_101 → status=4 both times, all matrices and counters unchanged.
- Bounce: button toggles every 2 cycles for 20 cycles, then held low → exactly one shot recorded.
- m_po has 2 ship cells; hit both → status=5, fim_jogo=1. A further press changes nothing. clr → all outputs 0.
- With `LIMITE_TIROS_EN` and MAX_TIROS=3: three misses → status=6, fim_jogo=1. Also pulse clr during CHECK → state IDLE and tiros=0 next cycle.
